// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver: FSM state encoding,
// baud divisor calculation and the RX FIFO entry layout.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;

  localparam int MAX_DATA_BITS = 9;

  // Data is zero-extended to the widest legal payload; narrower builds use the low bits.
  typedef struct packed {
    logic [MAX_DATA_BITS-1:0] data;
    logic                     frame_err;
    logic                     parity_err;
  } rx_entry_t;

  function automatic int calc_div(input int clock_freq, input int baud_rate);
    return (clock_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous first-word fall-through FIFO; DEPTH must be a power of two.
// A push into a full FIFO is taken only when a pop happens in the same cycle.
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q == {~rptr_q[AW], rptr_q[AW-1:0]});
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/uart_transceiver.sv
// UART transceiver with TX/RX FIFOs, configurable data width and stop bits.
// Define UART_PARITY_EN to add a parity bit after the data bits on both paths.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] io_tx_data,
  input  logic                 io_tx_valid,
  output logic                 io_tx_ready,
  output logic [DATA_BITS-1:0] io_rx_data,
  output logic                 io_rx_valid,
  input  logic                 io_rx_ready,
  output logic                 io_rx_frame_err,
  output logic                 io_rx_parity_err,
  output logic                 io_rx_overrun,
  input  logic                 io_parity_odd,
  output logic                 io_uart_tx,
  input  logic                 io_uart_rx
);
  localparam int            DIV     = calc_div(CLOCK_FREQ, BAUD_RATE);
  localparam int            CW      = $clog2(DIV);
  localparam int            ENTRY_W = $bits(rx_entry_t);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);
  localparam logic [3:0]    DB_M1   = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_M1   = 4'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
  localparam uart_state_e   AFTER_DATA = PARITY;
`else
  localparam uart_state_e   AFTER_DATA = STOP;
`endif

  uart_state_e          tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [CW-1:0]        tx_cnt_q, rx_cnt_q;
  logic [3:0]           tx_bit_q, rx_bit_q;
  logic [DATA_BITS-1:0] tx_sh_q, rx_sh_q, tx_head;
  logic                 tx_q, tx_d, tx_tick, tx_pop, tx_full, tx_empty;
  logic                 rx_s1_q, rx_s2_q, rx_s3_q, rx_ovr_q;
  logic                 rx_tick, rx_fall, rx_push, rx_pop, rx_full, rx_empty, rx_perr;
  logic [DATA_BITS+1:0] rx_rdata;
  rx_entry_t            rx_head;
  logic                 unused_head;

  // ---------------- TX ----------------
  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i(clock), .rst_i(reset), .push_i(io_tx_valid & io_tx_ready), .wdata_i(io_tx_data),
    .pop_i(tx_pop), .rdata_o(tx_head), .full_o(tx_full), .empty_o(tx_empty));

  assign io_tx_ready = ~tx_full;
  assign io_uart_tx  = tx_q;
  assign tx_tick     = (tx_cnt_q == DIV_M1);

`ifdef UART_PARITY_EN
  logic tx_par_q, rx_perr_q;
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_par_q  <= 1'b0;
      rx_perr_q <= 1'b0;
    end else begin
      if (tx_pop) tx_par_q <= ^tx_head ^ io_parity_odd;
      if (rx_state_q == IDLE) rx_perr_q <= 1'b0;
      else if (rx_state_q == PARITY && rx_tick) rx_perr_q <= rx_s2_q ^ (^rx_sh_q) ^ io_parity_odd;
    end
  end
  assign rx_perr = rx_perr_q;
`else
  assign rx_perr = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) tx_state_q <= IDLE;
    else       tx_state_q <= tx_state_d;
  end

  // Leaving STOP straight into START keeps consecutive frames gap-free.
  always_comb begin
    tx_state_d = tx_state_q;
    unique case (tx_state_q)
      IDLE:  if (!tx_empty) tx_state_d = START;
      START: if (tx_tick) tx_state_d = DATA;
      DATA:  if (tx_tick && tx_bit_q == DB_M1) tx_state_d = AFTER_DATA;
`ifdef UART_PARITY_EN
      PARITY: if (tx_tick) tx_state_d = STOP;
`endif
      STOP:  if (tx_tick && tx_bit_q == SB_M1) tx_state_d = tx_empty ? IDLE : START;
      default: tx_state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_d   = 1'b1;
    tx_pop = ~tx_empty & ((tx_state_q == IDLE) |
                          (tx_state_q == STOP && tx_tick && tx_bit_q == SB_M1));
    unique case (tx_state_q)
      START: tx_d = 1'b0;
      DATA:  tx_d = tx_sh_q[0];
`ifdef UART_PARITY_EN
      PARITY: tx_d = tx_par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_q     <= 1'b1;
      tx_cnt_q <= '0;
      tx_bit_q <= '0;
      tx_sh_q  <= '0;
    end else begin
      tx_q     <= tx_d;
      tx_cnt_q <= (tx_state_q == IDLE || tx_tick) ? '0 : tx_cnt_q + 1'b1;
      tx_bit_q <= (tx_state_d != tx_state_q) ? '0 : tx_bit_q + {3'b0, tx_tick};
      if (tx_pop) tx_sh_q <= tx_head;
      else if (tx_state_q == DATA && tx_tick) tx_sh_q <= tx_sh_q >> 1;
    end
  end

  // ---------------- RX ----------------
  assign rx_fall = rx_s3_q & ~rx_s2_q;
  assign rx_tick = (rx_state_q == START) ? (rx_cnt_q == HALF_M1) : (rx_cnt_q == DIV_M1);
  assign rx_pop  = io_rx_ready & ~rx_empty;

  always_ff @(posedge clock) begin
    if (reset) rx_state_q <= IDLE;
    else       rx_state_q <= rx_state_d;
  end

  always_comb begin
    rx_state_d = rx_state_q;
    unique case (rx_state_q)
      IDLE:  if (rx_fall) rx_state_d = START;
      START: if (rx_tick) rx_state_d = rx_s2_q ? IDLE : DATA;
      DATA:  if (rx_tick && rx_bit_q == DB_M1) rx_state_d = AFTER_DATA;
`ifdef UART_PARITY_EN
      PARITY: if (rx_tick) rx_state_d = STOP;
`endif
      STOP:  if (rx_tick) rx_state_d = IDLE;
      default: rx_state_d = IDLE;
    endcase
  end

  always_comb begin
    rx_push = (rx_state_q == STOP) && rx_tick;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      {rx_s3_q, rx_s2_q, rx_s1_q} <= 3'b111;
      rx_cnt_q <= '0;
      rx_bit_q <= '0;
      rx_sh_q  <= '0;
      rx_ovr_q <= 1'b0;
    end else begin
      {rx_s3_q, rx_s2_q, rx_s1_q} <= {rx_s2_q, rx_s1_q, io_uart_rx};
      rx_cnt_q <= (rx_state_q == IDLE || rx_tick) ? '0 : rx_cnt_q + 1'b1;
      rx_bit_q <= (rx_state_d != rx_state_q) ? '0 : rx_bit_q + {3'b0, rx_tick};
      if (rx_state_q == DATA && rx_tick) rx_sh_q <= {rx_s2_q, rx_sh_q[DATA_BITS-1:1]};
      rx_ovr_q <= rx_push & rx_full & ~rx_pop;
    end
  end

  uart_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i(clock), .rst_i(reset), .push_i(rx_push), .wdata_i({rx_sh_q, ~rx_s2_q, rx_perr}),
    .pop_i(rx_pop), .rdata_o(rx_rdata), .full_o(rx_full), .empty_o(rx_empty));

  assign rx_head         = rx_entry_t'(ENTRY_W'(rx_rdata));
  assign io_rx_valid     = ~rx_empty;
  assign io_rx_data      = rx_head.data[DATA_BITS-1:0];
  assign io_rx_frame_err = rx_head.frame_err;
  assign io_rx_overrun   = rx_ovr_q;
`ifdef UART_PARITY_EN
  assign io_rx_parity_err = rx_head.parity_err;
  assign unused_head      = ^rx_head.data;
`else
  assign io_rx_parity_err = 1'b0;
  assign unused_head      = ^{rx_head, io_parity_odd};
`endif

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed bench for uart_transceiver at DIV=16, FIFO_DEPTH=4; loopback or driven RX line.
module tb_uart_transceiver;
  localparam int DIV = 16, DB = 8, SB = 1, DEPTH = 4;
`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (1 + DB + P + SB) * DIV;

  logic clock = 0, reset = 1;
  logic [7:0] tx_data = 0, rx_data;
  logic tx_valid = 0, tx_ready, rx_valid, rx_ready = 1, fe, pe, ovr;
  logic parity_odd = 0, uart_tx, loop = 0, rx_drv = 1;
  wire  rx_line = loop ? uart_tx : rx_drv;

  int checks = 0, errors = 0, cyc = 0, ovr_cnt = 0, acc_cyc = 0;
  logic prev_tx = 1;
  int tq[$];
  logic [9:0] rxq[$];

  uart_transceiver #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(100_000), .DATA_BITS(DB),
                     .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .io_tx_data(tx_data), .io_tx_valid(tx_valid),
    .io_tx_ready(tx_ready), .io_rx_data(rx_data), .io_rx_valid(rx_valid),
    .io_rx_ready(rx_ready), .io_rx_frame_err(fe), .io_rx_parity_err(pe),
    .io_rx_overrun(ovr), .io_parity_odd(parity_odd), .io_uart_tx(uart_tx),
    .io_uart_rx(rx_line));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    prev_tx <= uart_tx;
    if (uart_tx !== prev_tx) tq.push_back(cyc);
    if (ovr) ovr_cnt <= ovr_cnt + 1;
  end

  always @(posedge clock) if (!reset && rx_valid && rx_ready) rxq.push_back({rx_data, fe, pe});

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input logic [7:0] d);
    int n = 0;
    @(negedge clock);
    while (!tx_ready && n < 4 * FRAME) begin @(negedge clock); n++; end
    tx_data = d; tx_valid = 1;
    @(posedge clock); #1;
    acc_cyc = cyc; tx_valid = 0;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && rxq.size() < n; i++) @(negedge clock);
    check(tag, rxq.size(), n);
  endtask

  task automatic wait_tq(input int n, input int budget);
    for (int i = 0; i < budget && tq.size() < n; i++) @(negedge clock);
    check("tx_edge_count", tq.size() >= n, 1);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop);
    @(negedge clock); rx_drv = 0;
    repeat (DIV) @(negedge clock);
    for (int i = 0; i < DB; i++) begin rx_drv = d[i]; repeat (DIV) @(negedge clock); end
`ifdef UART_PARITY_EN
    rx_drv = par; repeat (DIV) @(negedge clock);
`else
    if (par) rx_drv = 1;
`endif
    rx_drv = stop; repeat (DIV * SB) @(negedge clock);
    rx_drv = 1; repeat (DIV) @(negedge clock);
  endtask

  initial begin
    int a0, base;
    logic [7:0] d;
    repeat (3) @(negedge clock);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_err", fe, 0);
    check("rst_parity_err", pe, 0);
    check("rst_overrun", ovr, 0);
    reset = 0;

    // Two back-to-back 0x55 frames: latency, every bit DIV wide, no gap
    loop = 1;
    repeat (20) @(negedge clock);
    tq.delete(); rxq.delete();
    push_tx(8'h55); a0 = acc_cyc;
    push_tx(8'h55);
    wait_tq(20, 4 * FRAME);
    if (tq.size() >= 20) begin
      check("tx_latency", tq[0] - a0, 2);
      check("frame_len", tq[10] - tq[0], FRAME);
      for (int i = 0; i < 19; i++)
        check("bit_width", tq[i+1] - tq[i], ((i % 10) == 8) ? (1 + P) * DIV : DIV);
    end
    wait_rx("rx_55_count", 2, 2 * FRAME);
    for (int i = 0; i < 2 && i < rxq.size(); i++) check("rx_55", rxq[i], {8'h55, 2'b00});

    // Loopback 0x41..0x48 through a 4-deep TX FIFO
    tq.delete(); rxq.delete();
    for (int i = 0; i < 8; i++) push_tx(8'h41 + 8'(i));
    wait_rx("loop_count", 8, 12 * FRAME);
    for (int i = 0; i < 8 && i < rxq.size(); i++) check("loop_data", rxq[i], {8'h41 + 8'(i), 2'b00});
    if (tq.size() > 0) check("loop_no_gap", tq[$] - tq[0], 7 * FRAME + (9 + P) * DIV);

`ifdef UART_PARITY_EN
    tq.delete(); rxq.delete();
    push_tx(8'h07);
    wait_tq(1, 2 * FRAME);
    for (int i = 0; i < 2 * FRAME && tq.size() > 0 && cyc < tq[0] + 9 * DIV + DIV / 2; i++)
      @(negedge clock);
    check("tx_parity_bit", uart_tx, 1);
    wait_rx("par_loop_count", 1, 2 * FRAME);
    if (rxq.size() > 0) check("par_loop", rxq[0], {8'h07, 2'b00});
    loop = 0; rxq.delete();
    drive_frame(8'h07, 1'b0, 1'b1);
    wait_rx("par_err_count", 1, FRAME);
    if (rxq.size() > 0) check("par_err", rxq[0], {8'h07, 2'b01});
`endif

    // Stop bit driven low
    loop = 0; rxq.delete();
    d = 8'hA3;
    drive_frame(d, ^d, 1'b0);
    wait_rx("ferr_count", 1, FRAME);
    if (rxq.size() > 0) check("ferr_entry", rxq[0], {8'hA3, 2'b10});

    // Low glitch shorter than half a bit
    rxq.delete();
    @(negedge clock); rx_drv = 0;
    repeat (5) @(negedge clock);
    rx_drv = 1;
    repeat (2 * FRAME) @(negedge clock);
    check("glitch_no_entry", rxq.size(), 0);
    check("glitch_rx_valid", rx_valid, 0);

    // Break: line held low for several frames
    rxq.delete();
    rx_drv = 0;
    repeat (4 * FRAME) @(negedge clock);
    rx_drv = 1;
    repeat (FRAME) @(negedge clock);
    check("break_count", rxq.size(), 1);
    if (rxq.size() > 0) check("break_entry", rxq[0], {8'h00, 2'b10});

    // Overrun: five frames into a 4-deep RX FIFO with no consumer
    rx_ready = 0; rxq.delete(); base = ovr_cnt;
    for (int i = 0; i < 4; i++) begin d = 8'h10 + 8'(i); drive_frame(d, ^d, 1'b1); end
    check("ovr_before_5th", ovr_cnt - base, 0);
    check("ovr_rx_valid", rx_valid, 1);
    d = 8'h14; drive_frame(d, ^d, 1'b1);
    repeat (4) @(negedge clock);
    check("ovr_pulses", ovr_cnt - base, 1);
    check("ovr_head", rx_data, 8'h10);
    rx_ready = 1;
    wait_rx("ovr_kept", 4, 20);
    for (int i = 0; i < 4 && i < rxq.size(); i++) check("ovr_data", rxq[i], {8'h10 + 8'(i), 2'b00});
    repeat (FRAME) @(negedge clock);
    check("ovr_dropped", rxq.size(), 4);

    // Reset during the data bits of 0xA5 with 0x5A still queued
    loop = 1; rxq.delete();
    push_tx(8'hA5);
    push_tx(8'h5A);
    repeat (4 * DIV) @(negedge clock);
    reset = 1;
    @(posedge clock); #1;
    check("midrst_tx_high", uart_tx, 1);
    @(negedge clock);
    check("midrst_tx_ready", tx_ready, 1);
    check("midrst_rx_valid", rx_valid, 0);
    reset = 0;
    repeat (2 * FRAME) @(negedge clock);
    check("midrst_tx_flushed", rxq.size(), 0);
    push_tx(8'h3C);
    wait_rx("post_rst_count", 1, 2 * FRAME);
    if (rxq.size() > 0) check("post_rst_data", rxq[0], {8'h3C, 2'b00});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
